ecc_io_ctrl: RTL

ECC_IO_CTRL -- requirements
Module: ecc_io_ctrl

---
 rtl/ecc_io_ctrl.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ecc_io_ctrl.sv
// Serial operand loader / result unloader around a scalar-multiply core.
// Optional RUN watchdog enabled by defining ECC_IO_CTRL_WATCHDOG_EN.
module ecc_io_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NIB_W   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [NIB_W-1:0]  a,
  input  logic [NIB_W-1:0]  prime,
  input  logic [NIB_W-1:0]  k,
  input  logic [NIB_W-1:0]  Px,
  input  logic [NIB_W-1:0]  Py,
  output logic              o_core_start,
  output logic [DATA_W-1:0] o_a,
  output logic [DATA_W-1:0] o_prime,
  output logic [DATA_W-1:0] o_k,
  output logic [DATA_W-1:0] o_px,
  output logic [DATA_W-1:0] o_py,
  input  logic              i_core_done,
  input  logic [DATA_W-1:0] i_core_x,
  input  logic [DATA_W-1:0] i_core_y,
  output logic [NIB_W-1:0]  kPx,
  output logic [NIB_W-1:0]  kPy,
  output logic              done,
  output logic              o_busy,
  output logic              o_err
);

  localparam int unsigned NIBS = DATA_W / NIB_W;
  localparam int unsigned CntW = (NIBS > 1) ? $clog2(NIBS) : 1;
  localparam logic [CntW-1:0] LastNib = CntW'(NIBS - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StRun, StDone, StOut} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   load_idx;
  logic              first_q, first_d;
  logic              load_en, res_en;
  int unsigned       load_off, out_off;

  logic [DATA_W-1:0] a_q, prime_q, k_q, px_q, py_q;
  logic [DATA_W-1:0] x_q, y_q;

`ifdef ECC_IO_CTRL_WATCHDOG_EN
  localparam int unsigned WdW = $clog2(TIMEOUT + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    first_d  = 1'b0;
    load_en  = 1'b0;
    res_en   = 1'b0;
    // Nibble 0 is captured in IDLE itself, so the slice index is forced there.
    load_idx = (state_q == StIdle) ? '0 : cnt_q;
`ifdef ECC_IO_CTRL_WATCHDOG_EN
    wd_d     = wd_q;
    err_d    = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (i_start) begin
          load_en = 1'b1;
          cnt_d   = CntW'(1);
          state_d = StLoad;
        end
      end
      StLoad: begin
        load_en = 1'b1;
        if (cnt_q == LastNib) begin
          cnt_d   = '0;
          first_d = 1'b1;
          state_d = StRun;
`ifdef ECC_IO_CTRL_WATCHDOG_EN
          wd_d    = '0;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        // A completion seen in the launch cycle belongs to no job of ours.
        if (!first_q && i_core_done) begin
          res_en  = 1'b1;
          state_d = StDone;
        end
`ifdef ECC_IO_CTRL_WATCHDOG_EN
        else if (wd_q == WdW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      StDone: begin
        cnt_d   = '0;
        state_d = StOut;
      end
      StOut: begin
        if (cnt_q == LastNib) begin
          cnt_d   = '0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    load_off = 32'(load_idx) * NIB_W;
    out_off  = 32'(cnt_q) * NIB_W;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      first_q <= 1'b0;
      a_q     <= '0;
      prime_q <= '0;
      k_q     <= '0;
      px_q    <= '0;
      py_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
      if (load_en) begin
        a_q[load_off +: NIB_W]     <= a;
        prime_q[load_off +: NIB_W] <= prime;
        k_q[load_off +: NIB_W]     <= k;
        px_q[load_off +: NIB_W]    <= Px;
        py_q[load_off +: NIB_W]    <= Py;
      end
      if (res_en) begin
        x_q <= i_core_x;
        y_q <= i_core_y;
      end
    end
  end

`ifdef ECC_IO_CTRL_WATCHDOG_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      wd_q  <= wd_d;
      err_q <= err_d;
    end
  end
  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

  assign o_core_start = (state_q == StRun) && first_q;
  assign done         = (state_q == StDone);
  assign o_busy       = (state_q != StIdle);
  assign kPx          = (state_q == StOut) ? x_q[out_off +: NIB_W] : '0;
  assign kPy          = (state_q == StOut) ? y_q[out_off +: NIB_W] : '0;
  assign o_a          = a_q;
  assign o_prime      = prime_q;
  assign o_k          = k_q;
  assign o_px         = px_q;
  assign o_py         = py_q;

endmodule
